uart_tx: RTL and testbench

Serial transmitter for the AXI4-Lite UART: buffers bytes written by the register block in an internal FWFT FIFO and serialises them on `o_uart_tx` as start bit, 5–8 data bits LSB first, optional parity, and 1 or 2 stop bits. Bit timing comes from the shared baud strobe generator, which this block enables through `o_tx_strb_en`. It is the transmit counterpart of the UART receive path, uses the same configuration encoding and sits beside it under the UART top.

---
 rtl/uart_pkg.sv | 36 +++
 rtl/uart_tx_if.sv | 28 ++
 rtl/sync_fifo_fwft_with_clear.sv | 74 +++++++
 rtl/uart_tx.sv | 161 ++++++++++++++++
 tb/tb_uart_tx.sv | 377 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit state encoding and the configuration
// encoding used by both the transmit and receive paths.
package uart_pkg;

   localparam int UART_BYTE_W        = 8;
   localparam int UART_MIN_DATA_BITS = 5;

   // Parity seed encoding (i_parity)
   localparam logic PARITY_EVEN = 1'b0;
   localparam logic PARITY_ODD  = 1'b1;

   // Data-bit encoding (i_data_bits = number of data bits minus 5)
   localparam logic [1:0] DATA_BITS_5 = 2'd0;
   localparam logic [1:0] DATA_BITS_6 = 2'd1;
   localparam logic [1:0] DATA_BITS_7 = 2'd2;
   localparam logic [1:0] DATA_BITS_8 = 2'd3;

   // Stop-bit encoding (i_stop_bits)
   localparam logic STOP_BITS_1 = 1'b0;
   localparam logic STOP_BITS_2 = 1'b1;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      SEND_START  = 3'd1,
      SEND_DATA   = 3'd2,
      SEND_PARITY = 3'd3,
      SEND_STOP0  = 3'd4,
      SEND_STOP1  = 3'd5
   } tx_state_t;

   // Index of the last data bit of a frame for a given data-bit encoding.
   function automatic logic [2:0] last_bit_index(input logic [1:0] data_bits);
      return 3'(UART_MIN_DATA_BITS - 1) + {1'b0, data_bits};
   endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-write side of the UART transmitter: the register block pushes bytes
// and observes FIFO status and overflow through this bundle.
interface uart_tx_if;
   import uart_pkg::*;

   logic                   i_fifo_wr_en;
   logic [UART_BYTE_W-1:0] i_fifo_wr_data;
   logic                   o_fifo_full;
   logic                   o_fifo_empty;
   logic                   o_overflow_error;

   modport master (
      output i_fifo_wr_en,
      output i_fifo_wr_data,
      input  o_fifo_full,
      input  o_fifo_empty,
      input  o_overflow_error
   );

   modport slave (
      input  i_fifo_wr_en,
      input  i_fifo_wr_data,
      output o_fifo_full,
      output o_fifo_empty,
      output o_overflow_error
   );

endinterface

// File: rtl/sync_fifo_fwft_with_clear.sv
// Synchronous first-word-fall-through FIFO with a synchronous flush.
// The head entry is visible on o_rd_data whenever o_empty is low; a write
// while full is dropped, and a clear discards all entries.
module sync_fifo_fwft_with_clear #(
   parameter int DATA_WIDTH            = 8,
   parameter int DEPTH                 = 16,
   parameter int EXTRA_OUTPUT_REGISTER = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_wr_en,
   input  logic [DATA_WIDTH-1:0] i_wr_data,
   input  logic                  i_rd_en,
   output logic [DATA_WIDTH-1:0] o_rd_data,
   output logic                  o_full,
   output logic                  o_empty
);

   localparam int          AW      = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [AW:0]           wr_ptr;
   logic [AW:0]           rd_ptr;
   logic [AW:0]           rd_ptr_nxt;
   logic                  wr_ok;
   logic                  rd_ok;

   // Pointers carry one wrap bit so full and empty are distinguishable.
   assign o_empty    = (wr_ptr == rd_ptr);
   assign o_full     = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign wr_ok      = i_wr_en && !o_full && !i_clear;
   assign rd_ok      = i_rd_en && !o_empty;
   assign rd_ptr_nxt = rd_ptr + (rd_ok ? PTR_ONE : '0);

   // Pointer update; clear and reset both return the FIFO to empty.
   always_ff @(posedge clk) begin
      if (!rst_n || i_clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         rd_ptr <= rd_ptr_nxt;
      end
   end

   // Storage write; contents are data and need no reset.
   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr[AW-1:0]] <= i_wr_data;
      end
   end

   generate
      if (EXTRA_OUTPUT_REGISTER == 0) begin : g_direct_out
         assign o_rd_data = mem[rd_ptr[AW-1:0]];
      end else begin : g_reg_out
         logic [DATA_WIDTH-1:0] rd_q;
         // Preload the next head, bypassing a write that lands on it.
         always_ff @(posedge clk) begin
            if (wr_ok && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0])) begin
               rd_q <= i_wr_data;
            end else begin
               rd_q <= mem[rd_ptr_nxt[AW-1:0]];
            end
         end
         assign o_rd_data = rd_q;
      end
   endgenerate

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: queues bytes in a FWFT FIFO and serialises each one as
// start bit, 5-8 data bits LSB first, optional parity and 1 or 2 stop bits,
// advancing one bit per baud strobe. Line, strobe enable and busy are
// registered straight from the next-state values.
module uart_tx
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_parity,
   input  logic [1:0] i_data_bits,
   input  logic       i_stop_bits,
   input  logic       i_use_parity,
   input  logic       i_fifo_clear,
   uart_tx_if.slave   fifo_if,
   input  logic       i_tx_strb,
   output logic       o_tx_strb_en,
   output logic       o_uart_tx,
   output logic       o_busy
);

   tx_state_t              state_q,  state_nxt;
   logic [UART_BYTE_W-1:0] shreg_q,  shreg_nxt;
   logic                   acc_q,    acc_nxt;
   logic [2:0]             cnt_q,    cnt_nxt;
   logic [2:0]             last_q,   last_nxt;
   logic                   par_en_q, par_en_nxt;
   logic                   stop2_q,  stop2_nxt;
   logic                   tx_nxt;
   logic                   strb_en_nxt;
   logic                   ovf_q;

   logic                   fifo_rd_en;
   logic [UART_BYTE_W-1:0] fifo_rd_data;
   logic                   fifo_full;
   logic                   fifo_empty;

   sync_fifo_fwft_with_clear #(
      .DATA_WIDTH            (UART_BYTE_W),
      .DEPTH                 (FIFO_DEPTH),
      .EXTRA_OUTPUT_REGISTER (0)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_clear   (i_fifo_clear),
      .i_wr_en   (fifo_if.i_fifo_wr_en),
      .i_wr_data (fifo_if.i_fifo_wr_data),
      .i_rd_en   (fifo_rd_en),
      .o_rd_data (fifo_rd_data),
      .o_full    (fifo_full),
      .o_empty   (fifo_empty)
   );

   assign fifo_if.o_fifo_full      = fifo_full;
   assign fifo_if.o_fifo_empty     = fifo_empty;
   assign fifo_if.o_overflow_error = ovf_q;

   // Frame sequencing: pop and latch configuration in IDLE, then walk the bits on each strobe.
   always_comb begin
      state_nxt  = state_q;
      shreg_nxt  = shreg_q;
      acc_nxt    = acc_q;
      cnt_nxt    = cnt_q;
      last_nxt   = last_q;
      par_en_nxt = par_en_q;
      stop2_nxt  = stop2_q;
      fifo_rd_en = 1'b0;

      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               fifo_rd_en = 1'b1;
               shreg_nxt  = fifo_rd_data;
               last_nxt   = last_bit_index(i_data_bits);
               par_en_nxt = i_use_parity;
               stop2_nxt  = i_stop_bits;
               acc_nxt    = i_parity;
               state_nxt  = SEND_START;
            end
         end
         SEND_START: begin
            if (i_tx_strb) begin
               cnt_nxt   = 3'd0;
               state_nxt = SEND_DATA;
            end
         end
         SEND_DATA: begin
            if (i_tx_strb) begin
               acc_nxt   = acc_q ^ shreg_q[0];
               shreg_nxt = {1'b0, shreg_q[UART_BYTE_W-1:1]};
               cnt_nxt   = cnt_q + 3'd1;
               if (cnt_q == last_q) begin
                  state_nxt = par_en_q ? SEND_PARITY : SEND_STOP0;
               end
            end
         end
         SEND_PARITY: begin
            if (i_tx_strb) begin
               state_nxt = SEND_STOP0;
            end
         end
         SEND_STOP0: begin
            if (i_tx_strb) begin
               state_nxt = stop2_q ? SEND_STOP1 : IDLE;
            end
         end
         SEND_STOP1: begin
            if (i_tx_strb) begin
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Line level and strobe enable for the coming cycle; the enable is held
   // through the single IDLE cycle between back-to-back frames so the baud
   // counter keeps running.
   always_comb begin
      case (state_nxt)
         SEND_START:  tx_nxt = 1'b0;
         SEND_DATA:   tx_nxt = shreg_nxt[0];
         SEND_PARITY: tx_nxt = acc_nxt;
         default:     tx_nxt = 1'b1;
      endcase
      strb_en_nxt = (state_nxt != IDLE) ||
                    ((state_q != IDLE) && !fifo_empty && !i_fifo_clear);
   end

   // Control state and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         o_uart_tx    <= 1'b1;
         o_tx_strb_en <= 1'b0;
         o_busy       <= 1'b0;
         ovf_q        <= 1'b0;
      end else begin
         state_q      <= state_nxt;
         o_uart_tx    <= tx_nxt;
         o_tx_strb_en <= strb_en_nxt;
         o_busy       <= (state_nxt != IDLE);
         ovf_q        <= fifo_if.i_fifo_wr_en && fifo_full;
      end
   end

   // Frame datapath and latched configuration; always loaded before use.
   always_ff @(posedge clk) begin
      shreg_q  <= shreg_nxt;
      acc_q    <= acc_nxt;
      cnt_q    <= cnt_nxt;
      last_q   <= last_nxt;
      par_en_q <= par_en_nxt;
      stop2_q  <= stop2_nxt;
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: a baud-strobe model drives i_tx_strb, stimulus pushes
// expected frames into a queue, and a monitor rebuilds each frame from the
// line at every strobe and compares it when o_busy falls.
module tb_uart_tx;
   import uart_pkg::*;

   localparam int FIFO_DEPTH = 16;

   typedef struct packed {
      logic [11:0] bits;
      logic [3:0]  len;
   } frame_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       i_parity = 1'b0;
   logic [1:0] i_data_bits = 2'd3;
   logic       i_stop_bits = 1'b0;
   logic       i_use_parity = 1'b0;
   logic       i_fifo_clear = 1'b0;
   logic       tx_strb = 1'b0;
   logic       tx_strb_en;
   logic       uart_line;
   logic       busy;

   uart_tx_if bus();

   uart_tx #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_parity     (i_parity),
      .i_data_bits  (i_data_bits),
      .i_stop_bits  (i_stop_bits),
      .i_use_parity (i_use_parity),
      .i_fifo_clear (i_fifo_clear),
      .fifo_if      (bus),
      .i_tx_strb    (tx_strb),
      .o_tx_strb_en (tx_strb_en),
      .o_uart_tx    (uart_line),
      .o_busy       (busy)
   );

   int     n_pass = 0;
   int     n_checks = 0;
   int     baud = 16;
   bit     stall = 1'b0;
   int     ovf_count = 0;
   int     frames_seen = 0;
   frame_t exp_q[$];

   initial forever #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // Reference frame: start 0, data LSB first, parity = seed ^ XOR(data), stop 1s.
   function automatic frame_t model(input logic [7:0] d, input logic [1:0] db,
                                    input logic par_en, input logic par_odd, input logic stop2);
      frame_t f;
      int     n;
      logic [7:0] mask;
      n    = UART_MIN_DATA_BITS + int'(db);
      mask = 8'((1 << n) - 1);
      f.bits = 12'(32'(d & mask) << 1);
      f.len  = 4'(1 + n);
      if (par_en) begin
         f.bits[f.len] = par_odd ^ (^(d & mask));
         f.len = f.len + 4'd1;
      end
      f.bits[f.len] = 1'b1;
      f.len = f.len + 4'd1;
      if (stop2) begin
         f.bits[f.len] = 1'b1;
         f.len = f.len + 4'd1;
      end
      return f;
   endfunction

   // Baud generator model: counter held at zero while disabled or stalled.
   initial begin : strobe_gen
      int cnt;
      cnt = 0;
      forever begin
         @(posedge clk); #1;
         if (!tx_strb_en || stall) begin
            cnt = 0;
            tx_strb = 1'b0;
         end else begin
            cnt++;
            tx_strb = (cnt >= baud);
            if (cnt >= baud) cnt = 0;
         end
      end
   end

   // Monitor: line sampled at each strobe while busy; frame compared when busy falls.
   initial begin : monitor
      frame_t got;
      frame_t exp;
      logic   prev_line;
      logic   prev_strb;
      bit     in_frame;
      bit     first;
      in_frame = 1'b0;
      first = 1'b0;
      prev_line = 1'b1;
      prev_strb = 1'b0;
      got = '0;
      forever begin
         @(negedge clk);
         if (bus.o_overflow_error) ovf_count++;
         if (!rst_n) begin
            in_frame = 1'b0;
            continue;
         end
         if (busy && !in_frame) begin
            in_frame = 1'b1;
            got = '0;
            first = 1'b1;
         end
         if (in_frame && busy) begin
            if (!first && !prev_strb) chk("line_stable", 32'(uart_line), 32'(prev_line));
            if (tx_strb) begin
               if (got.len < 4'd12) got.bits[got.len] = uart_line;
               if (got.len != 4'hF) got.len = got.len + 4'd1;
            end
            first = 1'b0;
            prev_line = uart_line;
            prev_strb = tx_strb;
         end else if (in_frame) begin
            in_frame = 1'b0;
            frames_seen++;
            chk("frame_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               exp = exp_q.pop_front();
               chk("frame", 32'(got), 32'(exp));
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic write_byte(input logic [7:0] d);
      bus.i_fifo_wr_en   = 1'b1;
      bus.i_fifo_wr_data = d;
      tick();
      bus.i_fifo_wr_en   = 1'b0;
   endtask

   task automatic set_cfg(input logic [1:0] db, input logic par_en, input logic par_odd,
                          input logic stop2);
      i_data_bits  = db;
      i_use_parity = par_en;
      i_parity     = par_odd;
      i_stop_bits  = stop2;
   endtask

   task automatic wait_idle(input string name, input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         @(negedge clk);
         if (!busy && bus.o_fifo_empty && exp_q.size() == 0) begin
            ok = 1'b1;
            break;
         end
      end
      chk(name, 32'(ok), 32'd1);
      tick();
   endtask

   task automatic wait_strobes(input int n, input int budget);
      int seen;
      seen = 0;
      for (int i = 0; i < budget && seen < n; i++) begin
         @(negedge clk);
         if (tx_strb) seen++;
      end
      chk("strobe_wait", 32'(seen), 32'(n));
      tick();
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_line"},  32'(uart_line), 32'd1);
      chk({tag, "_en"},    32'(tx_strb_en), 32'd0);
      chk({tag, "_busy"},  32'(busy), 32'd0);
      chk({tag, "_ovf"},   32'(bus.o_overflow_error), 32'd0);
      chk({tag, "_empty"}, 32'(bus.o_fifo_empty), 32'd1);
      chk({tag, "_full"},  32'(bus.o_fifo_full), 32'd0);
   endtask

   initial begin : stimulus
      logic [7:0] d;
      bit         started;
      int         gaps;
      int         en_drops;
      bit         done;
      bit         busy_seen;

      bus.i_fifo_wr_en   = 1'b0;
      bus.i_fifo_wr_data = 8'h00;

      // Reset
      rst_n = 1'b0;
      repeat (3) tick();
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_outputs("reset");
      tick();

      // 8N1 0xA5 with frame-start timing
      set_cfg(DATA_BITS_8, 1'b0, PARITY_EVEN, STOP_BITS_1);
      baud = 16;
      exp_q.push_back('{bits: 12'h34A, len: 4'd10});
      write_byte(8'hA5);
      @(negedge clk);
      chk("start_w1_empty", 32'(bus.o_fifo_empty), 32'd0);
      chk("start_w1_busy",  32'(busy), 32'd0);
      chk("start_w1_line",  32'(uart_line), 32'd1);
      tick();
      @(negedge clk);
      chk("start_w2_line",  32'(uart_line), 32'd0);
      chk("start_w2_en",    32'(tx_strb_en), 32'd1);
      chk("start_w2_busy",  32'(busy), 32'd1);
      chk("start_w2_empty", 32'(bus.o_fifo_empty), 32'd1);
      tick();
      wait_idle("idle_8n1", 400);
      chk("en_after_8n1", 32'(tx_strb_en), 32'd0);

      // 7E2 0x53
      set_cfg(DATA_BITS_7, 1'b1, PARITY_EVEN, STOP_BITS_2);
      exp_q.push_back('{bits: 12'h6A6, len: 4'd11});
      write_byte(8'h53);
      wait_idle("idle_7e2", 400);

      // 5O1 0x1F
      set_cfg(DATA_BITS_5, 1'b1, PARITY_ODD, STOP_BITS_1);
      exp_q.push_back('{bits: 12'h0BE, len: 4'd8});
      write_byte(8'h1F);
      wait_idle("idle_5o1", 400);

      // Back-to-back 8N1 frames
      set_cfg(DATA_BITS_8, 1'b0, PARITY_EVEN, STOP_BITS_1);
      exp_q.push_back(model(8'h00, DATA_BITS_8, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(model(8'hFF, DATA_BITS_8, 1'b0, 1'b0, 1'b0));
      exp_q.push_back(model(8'h3C, DATA_BITS_8, 1'b0, 1'b0, 1'b0));
      write_byte(8'h00);
      write_byte(8'hFF);
      write_byte(8'h3C);
      started = 1'b0;
      gaps = 0;
      en_drops = 0;
      done = 1'b0;
      for (int i = 0; i < 1200; i++) begin
         @(negedge clk);
         if (busy) started = 1'b1;
         if (started && !busy && bus.o_fifo_empty) begin
            done = 1'b1;
            break;
         end
         if (started && !busy) gaps++;
         if (started && !tx_strb_en) en_drops++;
      end
      chk("b2b_done", 32'(done), 32'd1);
      chk("b2b_gap_cycles", 32'(gaps), 32'd2);
      chk("b2b_en_drops", 32'(en_drops), 32'd0);
      tick();
      wait_idle("idle_b2b", 20);

      // Overflow with the line stalled: the first byte moves into the shift
      // register, so 17 writes fill the FIFO and the 18th is dropped.
      stall = 1'b1;
      for (int i = 0; i < 17; i++) begin
         d = 8'($urandom);
         exp_q.push_back(model(d, DATA_BITS_8, 1'b0, 1'b0, 1'b0));
         write_byte(d);
      end
      @(negedge clk);
      chk("ovf_full", 32'(bus.o_fifo_full), 32'd1);
      chk("ovf_none_yet", 32'(bus.o_overflow_error), 32'd0);
      tick();
      write_byte(8'hEE);
      @(negedge clk);
      chk("ovf_pulse", 32'(bus.o_overflow_error), 32'd1);
      tick();
      @(negedge clk);
      chk("ovf_pulse_end", 32'(bus.o_overflow_error), 32'd0);
      chk("ovf_still_full", 32'(bus.o_fifo_full), 32'd1);
      tick();
      stall = 1'b0;
      wait_idle("idle_ovf", 17 * 200);

      // Clear during data bit 3 of the first of four queued frames
      d = 8'($urandom);
      exp_q.push_back(model(d, DATA_BITS_8, 1'b0, 1'b0, 1'b0));
      write_byte(d);
      for (int i = 0; i < 3; i++) write_byte(8'($urandom));
      wait_strobes(4, 200);
      repeat (3) tick();
      i_fifo_clear = 1'b1;
      tick();
      i_fifo_clear = 1'b0;
      @(negedge clk);
      chk("clear_empty", 32'(bus.o_fifo_empty), 32'd1);
      chk("clear_busy", 32'(busy), 32'd1);
      tick();
      wait_idle("idle_clear", 400);
      busy_seen = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (busy) busy_seen = 1'b1;
      end
      chk("clear_no_more_frames", 32'(busy_seen), 32'd0);
      chk("clear_still_empty", 32'(bus.o_fifo_empty), 32'd1);
      tick();

      // Reset during the parity bit of an 8E1 frame
      set_cfg(DATA_BITS_8, 1'b1, PARITY_EVEN, STOP_BITS_1);
      d = 8'($urandom);
      exp_q.push_back(model(d, DATA_BITS_8, 1'b1, 1'b0, 1'b0));
      write_byte(d);
      wait_strobes(9, 300);
      repeat (2) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_reset_outputs("midrst");
      tick();
      set_cfg(DATA_BITS_8, 1'b0, PARITY_EVEN, STOP_BITS_1);
      d = 8'($urandom);
      exp_q.push_back(model(d, DATA_BITS_8, 1'b0, 1'b0, 1'b0));
      write_byte(d);
      wait_idle("idle_after_rst", 400);

      // Randomized frames; configuration scrambled once each frame is under way
      for (int t = 0; t < 20; t++) begin
         logic [1:0] db;
         logic       pe, po, s2;
         db = 2'($urandom);
         pe = 1'($urandom);
         po = 1'($urandom);
         s2 = 1'($urandom);
         baud = $urandom_range(3, 20);
         set_cfg(db, pe, po, s2);
         d = 8'($urandom);
         exp_q.push_back(model(d, db, pe, po, s2));
         write_byte(d);
         done = 1'b0;
         for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (busy) begin
               done = 1'b1;
               break;
            end
         end
         chk("rand_busy", 32'(done), 32'd1);
         tick();
         {i_parity, i_data_bits, i_stop_bits, i_use_parity} = 5'($urandom);
         wait_idle("idle_rand", 12 * 21 + 20);
      end

      chk("ovf_pulse_total", 32'(ovf_count), 32'd1);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
